regpair_sequencer: RTL and testbench

Command-driven initiator for the core's 8-register file. Accepts one register-transfer micro-op at a time over a valid/ready handshake. Runs the op as a fixed read/write sequence on the register file's single write port and two read ports (write enable/address/data, read enables/addresses, read data). Covers 8085 immediate load, register move, 16-bit pair increment/decrement and pair exchange.

---
 rtl/regpair_pkg.sv | 30 +++
 rtl/pair_incdec.sv | 22 ++
 rtl/regpair_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_regpair_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regpair_pkg.sv
// Shared definitions for the register-pair sequencer: opcodes, FSM states
// and the pair-to-register address helper.
package regpair_pkg;

    localparam int REG_DATASIZE = 8;
    localparam int REG_ADDRSIZE = 3;

    localparam logic [2:0] OP_MVI  = 3'd0;
    localparam logic [2:0] OP_MOV  = 3'd1;
    localparam logic [2:0] OP_INX  = 3'd2;
    localparam logic [2:0] OP_DCX  = 3'd3;
    localparam logic [2:0] OP_XCHG = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_WR,
        ST_ERR
    } state_t;

    // Pair p lives in registers 2p (high, i_low=0) and 2p+1 (low, i_low=1).
    function automatic logic [REG_ADDRSIZE-1:0] pair_reg(
        input logic [REG_ADDRSIZE-1:0] i_reg,
        input logic                    i_low
    );
        return {i_reg[REG_ADDRSIZE-1:1], i_low};
    endfunction

endpackage

// File: rtl/pair_incdec.sv
// Combinational +1/-1 on a register pair treated as one 2*DATASIZE-bit value.
module pair_incdec #(
    parameter int DATASIZE = 8
) (
    input  logic [DATASIZE-1:0] i_hi,
    input  logic [DATASIZE-1:0] i_lo,
    input  logic                i_dec,
    output logic [DATASIZE-1:0] o_hi,
    output logic [DATASIZE-1:0] o_lo
);

    localparam logic [2*DATASIZE-1:0] ONE = {{(2*DATASIZE-1){1'b0}}, 1'b1};

    logic [2*DATASIZE-1:0] w_pair;
    logic [2*DATASIZE-1:0] w_result;

    assign w_pair   = {i_hi, i_lo};
    assign w_result = i_dec ? (w_pair - ONE) : (w_pair + ONE);
    assign o_hi     = w_result[2*DATASIZE-1:DATASIZE];
    assign o_lo     = w_result[DATASIZE-1:0];

endmodule

// File: rtl/regpair_sequencer.sv
// Runs one MVI/MOV/INX/DCX/XCHG micro-op at a time as a fixed read/write
// sequence on a 1-write/2-read register file.
module regpair_sequencer
    import regpair_pkg::*;
#(
    parameter int DATASIZE = REG_DATASIZE,
    parameter int ADDRSIZE = REG_ADDRSIZE
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [2:0]          i_cmd_op,
    input  logic [ADDRSIZE-1:0] i_cmd_dst,
    input  logic [ADDRSIZE-1:0] i_cmd_src,
    input  logic [DATASIZE-1:0] i_cmd_imm,
    output logic                o_done,
    output logic                o_err,
    output logic                o_wrenb,
    output logic [ADDRSIZE-1:0] o_waddr,
    output logic [DATASIZE-1:0] o_wdata,
    output logic                o_r1enb,
    output logic [ADDRSIZE-1:0] o_r1add,
    output logic                o_r2enb,
    output logic [ADDRSIZE-1:0] o_r2add,
    input  logic [DATASIZE-1:0] i_r1dat,
    input  logic [DATASIZE-1:0] i_r2dat
);

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_op;
    logic [ADDRSIZE-1:0] r_dst;
    logic [ADDRSIZE-1:0] r_src;
    logic [DATASIZE-1:0] r_imm;
    logic [DATASIZE-1:0] r_t0, r_t1, r_t2, r_t3;
    logic [1:0]          r_wcnt;
    logic                w_last;
    logic                w_ready;
    logic [DATASIZE-1:0] w_inc_hi, w_inc_lo;

    pair_incdec #(.DATASIZE(DATASIZE)) u_incdec (
        .i_hi  (i_r1dat),
        .i_lo  (i_r2dat),
        .i_dec (r_op == OP_DCX),
        .o_hi  (w_inc_hi),
        .o_lo  (w_inc_lo)
    );

    // Ready is held low while reset is asserted so every output reads 0 then.
    assign o_cmd_ready = w_ready & i_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_last  = 1'b0;
        o_done  = 1'b0;
        o_err   = 1'b0;
        o_wrenb = 1'b0;
        o_waddr = '0;
        o_wdata = '0;
        o_r1enb = 1'b0;
        o_r1add = '0;
        o_r2enb = 1'b0;
        o_r2add = '0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (i_cmd_valid) begin
                    case (i_cmd_op)
                        OP_MVI:                          w_next = ST_WR;
                        OP_MOV, OP_INX, OP_DCX, OP_XCHG: w_next = ST_RD_A;
                        default:                         w_next = ST_ERR;
                    endcase
                end
            end
            ST_RD_A: begin
                o_r1enb = 1'b1;
                o_r2enb = 1'b1;
                if (r_op == OP_MOV) begin
                    o_r1add = r_src;
                    o_r2add = r_src;
                end else begin
                    o_r1add = pair_reg(r_dst, 1'b0);
                    o_r2add = pair_reg(r_dst, 1'b1);
                end
                w_next = (r_op == OP_XCHG) ? ST_RD_B : ST_WR;
            end
            ST_RD_B: begin
                o_r1enb = 1'b1;
                o_r2enb = 1'b1;
                o_r1add = pair_reg(r_src, 1'b0);
                o_r2add = pair_reg(r_src, 1'b1);
                w_next  = ST_WR;
            end
            ST_WR: begin
                o_wrenb = 1'b1;
                case (r_op)
                    OP_MVI: begin
                        o_waddr = r_dst;
                        o_wdata = r_imm;
                        w_last  = 1'b1;
                    end
                    OP_MOV: begin
                        o_waddr = r_dst;
                        o_wdata = r_t0;
                        w_last  = 1'b1;
                    end
                    OP_INX, OP_DCX: begin
                        // Low byte first, then high byte.
                        if (r_wcnt == 2'd0) begin
                            o_waddr = pair_reg(r_dst, 1'b1);
                            o_wdata = r_t1;
                        end else begin
                            o_waddr = pair_reg(r_dst, 1'b0);
                            o_wdata = r_t0;
                            w_last  = 1'b1;
                        end
                    end
                    OP_XCHG: begin
                        case (r_wcnt)
                            2'd0: begin
                                o_waddr = pair_reg(r_dst, 1'b0);
                                o_wdata = r_t2;
                            end
                            2'd1: begin
                                o_waddr = pair_reg(r_dst, 1'b1);
                                o_wdata = r_t3;
                            end
                            2'd2: begin
                                o_waddr = pair_reg(r_src, 1'b0);
                                o_wdata = r_t0;
                            end
                            default: begin
                                o_waddr = pair_reg(r_src, 1'b1);
                                o_wdata = r_t1;
                                w_last  = 1'b1;
                            end
                        endcase
                    end
                    default: w_last = 1'b1;
                endcase
                if (w_last) begin
                    o_done = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_ERR: begin
                o_done = 1'b1;
                o_err  = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op   <= '0;
            r_dst  <= '0;
            r_src  <= '0;
            r_imm  <= '0;
            r_t0   <= '0;
            r_t1   <= '0;
            r_t2   <= '0;
            r_t3   <= '0;
            r_wcnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wcnt <= '0;
                    if (i_cmd_valid) begin
                        r_op  <= i_cmd_op;
                        r_dst <= i_cmd_dst;
                        r_src <= i_cmd_src;
                        r_imm <= i_cmd_imm;
                    end
                end
                ST_RD_A: begin
                    if (r_op == OP_INX || r_op == OP_DCX) begin
                        r_t0 <= w_inc_hi;
                        r_t1 <= w_inc_lo;
                    end else begin
                        r_t0 <= i_r1dat;
                        r_t1 <= i_r2dat;
                    end
                end
                ST_RD_B: begin
                    r_t2 <= i_r1dat;
                    r_t3 <= i_r2dat;
                end
                ST_WR: begin
                    r_wcnt <= w_last ? 2'd0 : r_wcnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regpair_sequencer.sv
// Directed bench: drives regpair_sequencer against an 8x8 tri-state register
// file model and checks write sequences, timing and final register contents.
module tb_regpair_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_dst;
    logic [2:0] cmd_src;
    logic [7:0] cmd_imm;
    logic       done;
    logic       err;
    logic       wrenb;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic       r1enb;
    logic [2:0] r1add;
    logic       r2enb;
    logic [2:0] r2add;
    wire  [7:0] r1dat;
    wire  [7:0] r2dat;

    logic [7:0] mem [8] = '{default: 8'h00};

    int checks   = 0;
    int failures = 0;

    int         busy;
    int         nWr;
    int         nRd;
    int         errCnt;
    int         timedOut;
    int         readyAfter;
    int         doneWithWr;
    int         rdInWr = 0;
    logic [2:0] wAddr [4];
    logic [7:0] wData [4];
    logic [2:0] rdAddr1 [2];
    logic [2:0] rdAddr2 [2];

    regpair_sequencer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_dst   (cmd_dst),
        .i_cmd_src   (cmd_src),
        .i_cmd_imm   (cmd_imm),
        .o_done      (done),
        .o_err       (err),
        .o_wrenb     (wrenb),
        .o_waddr     (waddr),
        .o_wdata     (wdata),
        .o_r1enb     (r1enb),
        .o_r1add     (r1add),
        .o_r2enb     (r2enb),
        .o_r2add     (r2add),
        .i_r1dat     (r1dat),
        .i_r2dat     (r2dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wrenb) mem[waddr] <= wdata;
    end

    assign r1dat = r1enb ? mem[r1add] : 8'bz;
    assign r2dat = r2enb ? mem[r2add] : 8'bz;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one command, scrambles the cmd_* inputs right after accept, and
    // records every busy cycle up to done. Returns at the negedge after done.
    task automatic applyStimulus(input logic [2:0] op, input logic [2:0] dst,
                                 input logic [2:0] src, input logic [7:0] imm);
        int guard;
        busy = 0; nWr = 0; nRd = 0; errCnt = 0; timedOut = 1;
        readyAfter = 0; doneWithWr = 0;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_src   = src;
        cmd_imm   = imm;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'd7;
        cmd_dst   = ~dst;
        cmd_src   = ~src;
        cmd_imm   = ~imm;
        for (int c = 0; c < 20; c++) begin
            if (!cmd_ready) busy++;
            if (err) errCnt++;
            if (r1enb && wrenb) rdInWr++;
            if (wrenb) begin
                if (nWr < 4) begin
                    wAddr[nWr] = waddr;
                    wData[nWr] = wdata;
                end
                nWr++;
            end
            if (r1enb) begin
                if (nRd < 2) begin
                    rdAddr1[nRd] = r1add;
                    rdAddr2[nRd] = r2add;
                end
                nRd++;
            end
            if (done) begin
                doneWithWr = wrenb;
                timedOut   = 0;
                @(negedge clk);
                readyAfter = cmd_ready;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic checkCmd(input string tag, input int expBusy, input int expNwr,
                            input int expErr);
        checkOutput({tag, "_timeout"}, timedOut, 0);
        checkOutput({tag, "_busy"}, busy, expBusy);
        checkOutput({tag, "_nwr"}, nWr, expNwr);
        checkOutput({tag, "_err"}, errCnt, expErr);
        checkOutput({tag, "_ready_after_done"}, readyAfter, 1);
        checkOutput({tag, "_done_on_last_wr"}, doneWithWr, (expNwr != 0) ? 1 : 0);
    endtask

    task automatic checkWrite(input string tag, input int idx, input logic [2:0] addr,
                              input logic [7:0] data);
        checkOutput({tag, "_waddr"}, wAddr[idx], addr);
        checkOutput({tag, "_wdata"}, wData[idx], data);
    endtask

    initial begin
        int doneSeen;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_dst   = 3'd0;
        cmd_src   = 3'd0;
        cmd_imm   = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", cmd_ready, 0);
        checkOutput("rst_wrenb", wrenb, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_r1enb", r1enb, 0);
        checkOutput("rst_r2enb", r2enb, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_rst", cmd_ready, 1);

        applyStimulus(3'd0, 3'd3, 3'd0, 8'h5A);
        checkCmd("mvi_r3", 1, 1, 0);
        checkWrite("mvi_r3", 0, 3'd3, 8'h5A);
        checkOutput("mvi_r3_mem", mem[3], 8'h5A);

        applyStimulus(3'd0, 3'd0, 3'd0, 8'h12);
        applyStimulus(3'd1, 3'd7, 3'd0, 8'h00);
        checkCmd("mov_r7_r0", 2, 1, 0);
        checkOutput("mov_rd_addr", rdAddr1[0], 3'd0);
        checkWrite("mov_r7_r0", 0, 3'd7, 8'h12);
        checkOutput("mov_r7_mem", mem[7], 8'h12);
        checkOutput("mov_r0_mem", mem[0], 8'h12);

        applyStimulus(3'd0, 3'd0, 3'd0, 8'hFF);
        applyStimulus(3'd0, 3'd1, 3'd0, 8'hFF);
        applyStimulus(3'd2, 3'd0, 3'd0, 8'h00);
        checkCmd("inx_wrap", 3, 2, 0);
        checkWrite("inx_wrap_w0", 0, 3'd1, 8'h00);
        checkWrite("inx_wrap_w1", 1, 3'd0, 8'h00);
        checkOutput("inx_wrap_pair", {mem[0], mem[1]}, 16'h0000);

        applyStimulus(3'd3, 3'd1, 3'd0, 8'h00);
        checkCmd("dcx_wrap", 3, 2, 0);
        checkWrite("dcx_wrap_w0", 0, 3'd1, 8'hFF);
        checkWrite("dcx_wrap_w1", 1, 3'd0, 8'hFF);
        checkOutput("dcx_wrap_pair", {mem[0], mem[1]}, 16'hFFFF);

        applyStimulus(3'd0, 3'd6, 3'd0, 8'h12);
        applyStimulus(3'd0, 3'd7, 3'd0, 8'hFF);
        applyStimulus(3'd2, 3'd7, 3'd0, 8'h00);
        checkCmd("inx_carry", 3, 2, 0);
        checkWrite("inx_carry_w0", 0, 3'd7, 8'h00);
        checkWrite("inx_carry_w1", 1, 3'd6, 8'h13);
        checkOutput("inx_carry_pair", {mem[6], mem[7]}, 16'h1300);

        applyStimulus(3'd0, 3'd2, 3'd0, 8'h12);
        applyStimulus(3'd0, 3'd3, 3'd0, 8'h34);
        applyStimulus(3'd0, 3'd4, 3'd0, 8'hAB);
        applyStimulus(3'd0, 3'd5, 3'd0, 8'hCD);
        applyStimulus(3'd4, 3'd2, 3'd5, 8'h00);
        checkCmd("xchg12", 6, 4, 0);
        checkOutput("xchg12_rda_hi", rdAddr1[0], 3'd2);
        checkOutput("xchg12_rda_lo", rdAddr2[0], 3'd3);
        checkOutput("xchg12_rdb_hi", rdAddr1[1], 3'd4);
        checkOutput("xchg12_rdb_lo", rdAddr2[1], 3'd5);
        checkWrite("xchg12_w0", 0, 3'd2, 8'hAB);
        checkWrite("xchg12_w1", 1, 3'd3, 8'hCD);
        checkWrite("xchg12_w2", 2, 3'd4, 8'h12);
        checkWrite("xchg12_w3", 3, 3'd5, 8'h34);
        checkOutput("xchg12_de", {mem[2], mem[3]}, 16'hABCD);
        checkOutput("xchg12_hl", {mem[4], mem[5]}, 16'h1234);

        applyStimulus(3'd4, 3'd3, 3'd2, 8'h00);
        checkCmd("xchg11", 6, 4, 0);
        checkOutput("xchg11_de", {mem[2], mem[3]}, 16'hABCD);

        applyStimulus(3'd6, 3'd0, 3'd0, 8'h00);
        checkCmd("illegal", 1, 0, 1);
        applyStimulus(3'd0, 3'd6, 3'd0, 8'h77);
        checkCmd("after_illegal", 1, 1, 0);
        checkOutput("after_illegal_mem", mem[6], 8'h77);

        applyStimulus(3'd1, 3'd5, 3'd5, 8'h00);
        checkCmd("mov_self", 2, 1, 0);
        checkWrite("mov_self", 0, 3'd5, 8'h34);

        // XCHG pair2,pair1 interrupted by reset during its third write (to r2).
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_dst   = 3'd4;
        cmd_src   = 3'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("midrst_wrenb_before", wrenb, 1);
        checkOutput("midrst_waddr_before", waddr, 3'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_wrenb_in_rst", wrenb, 0);
        checkOutput("midrst_ready_in_rst", cmd_ready, 0);
        doneSeen = 0;
        @(negedge clk);
        if (done) doneSeen++;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("midrst_no_done", doneSeen, 0);
        checkOutput("midrst_ready", cmd_ready, 1);
        checkOutput("midrst_r4", mem[4], 8'hAB);
        checkOutput("midrst_r5", mem[5], 8'hCD);
        checkOutput("midrst_r2", mem[2], 8'hAB);
        checkOutput("midrst_r3", mem[3], 8'hCD);

        checkOutput("no_read_in_wr", rdInWr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
